parity_frame_rx: RTL and testbench
==================================

# parity_frame_rx

Serial frame receiver that feeds the parity-checking datapath. It deserialises start/data/parity/stop frames sampled on a bit-rate strobe and checks the word's parity against the received parity bit. It presents each word with parity and framing error flags through a one-entry valid/ready output buffer. An optional saturating parity-error counter is included.

## Interface
- DATA_W, 8, data bits per frame, 1..16
- ODD_PAR, 0, 0 = even parity convention, 1 = odd parity convention
- Clk  in  1  single clock, rising edge
- RstN  in  1  asynchronous active-low reset
- BitEn  in  1  bit-rate strobe; SerIn is sampled only on cycles with BitEn=1
- SerIn  in  1  serial line, idle high
- OutData  out  DATA_W  received word, LSB first on line
- ParErr  out  1  parity mismatch for OutData
- FrameErr  out  1  stop bit sampled 0 for OutData
- OutValid  out  1  buffer holds a word
- OutReady  in  1  consumer accepts when OutValid&&OutReady
- Overrun  out  1  one-cycle pulse; a completed frame was dropped
- CntClr  in  1  synchronous clear of ErrCount (PARITY_ERR_CNT_EN only)
- ErrCount  out  16  saturating parity-error count (PARITY_ERR_CNT_EN only)

## Operation
- States: IDLE, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: on BitEn with SerIn=0 (start bit) -> DATA, bit index=0.
- DATA: on each BitEn, shift SerIn into bit[index], LSB first. After bit DATA_W-1 -> PARITY.
- PARITY: on BitEn, capture the parity bit -> STOP.
- STOP: on BitEn, the frame completes.
  - SerIn=1 -> IDLE.
  - SerIn=0 -> FrameErr set for this word; go to WAIT_HIGH.
- WAIT_HIGH: on BitEn with SerIn=1 -> IDLE. This stops a held-low line from re-triggering frames.
- ParErr = (XOR of data bits ^ parity bit) != ODD_PAR.
- Cycles with BitEn=0 change no state.
- Buffer load on frame completion:
  - Buffer empty, or popped on the same edge (OutValid&&OutReady): load the word and flags, OutValid=1.
  - Buffer full and not popped: drop the word, keep the held word unchanged, Overrun=1 for one cycle.
- A pop with no completion clears OutValid. OutData and flags keep their last value.
- Reset values: state=IDLE, index=0, OutData=0, ParErr=0, FrameErr=0, OutValid=0, Overrun=0, ErrCount=0.
- Reset mid-frame discards the partial frame.

## Timing
- OutValid, OutData and the flags update on the same edge as the stop-bit BitEn sample. They are visible from that edge on.
- Latency from the start-bit sample to OutValid is DATA_W+2 BitEn strobes.
- A simultaneous pop and completion on one edge is a replacement: OutValid stays 1 and the new word is visible the next cycle.
- BitEn may be asserted every cycle. Back-to-back frames need no idle gap.

## Configuration
- PARITY_ERR_CNT_EN defined:
  - ErrCount and CntClr ports exist.
  - ErrCount increments on each edge where a word with ParErr=1 is loaded into the buffer. Dropped (overrun) words are not counted.
  - ErrCount saturates at 0xFFFF.
  - CntClr has priority over a same-edge increment; the result is 0.
- PARITY_ERR_CNT_EN undefined: ErrCount and CntClr are absent and no counter logic is built.

## Structure
- Package parity_rx_pkg holds:
  - state enum rx_state_t (IDLE, DATA, PARITY, STOP, WAIT_HIGH)
  - constant ERR_CNT_W=16
  - constant ERR_CNT_MAX
- Sub-module par_rx_outbuf: the one-entry valid/ready holding register with overrun detection. Inputs are word, flags and a load strobe. Outputs are the Out* ports and Overrun.

## Test plan
- DATA_W=8, ODD_PAR=0, frame 0xA5 with parity 0 and stop 1 -> OutData=0xA5, ParErr=0, FrameErr=0, OutValid=1 after 10 strobes.
- Frame 0xA5 with parity 1 -> ParErr=1. With PARITY_ERR_CNT_EN, ErrCount=1. Pulse CntClr -> ErrCount=0.
- Frame 0x3C with stop bit 0, then SerIn held 0 for 20 strobes -> FrameErr=1, no new frame. SerIn=1 then start -> reception resumes.
- Two frames 0x11 and 0x22 with OutReady=0 -> OutData stays 0x11 and Overrun pulses once. With OutReady=1 at the second completion -> OutData=0x22 and no Overrun.
- RstN low after 4 data bits, then a clean frame 0x5A -> only 0x5A is delivered, and all outputs read 0 during reset.
- ODD_PAR=1, frame 0x00 with parity 1 -> ParErr=0. Frame 0x00 with parity 0 -> ParErr=1.

Source files
------------

// File: rtl/parity_rx_pkg.sv
// Shared types and constants for the parity frame receiver.
// The optional parity-error counter is enabled with PARITY_ERR_CNT_EN.
package parity_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam int ERR_CNT_W = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 16'hFFFF;

    // Parity mismatch for a word zero-extended to 16 bits (zero bits do not change the XOR).
    function automatic logic calc_par_err(input logic [15:0] word,
                                          input logic        par_bit,
                                          input logic        odd_par);
        logic x;
        x = (^word) ^ par_bit;
        return (x != odd_par);
    endfunction

endpackage

// File: rtl/par_rx_outbuf.sv
// One-entry valid/ready holding register for received words.
// A completion that finds the buffer full and not being popped is dropped
// and reported with a one-cycle overrun pulse; the held word is untouched.
module par_rx_outbuf #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              par_err_i,
    input  logic              frame_err_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              par_err_o,
    output logic              frame_err_o,
    output logic              valid_o,
    output logic              overrun_o
);

    logic [DATA_W-1:0] data_q;
    logic              par_err_q;
    logic              frame_err_q;
    logic              valid_q;
    logic              overrun_q;

    // Load, replace, pop or drop the held word; overrun pulses for one cycle on a drop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q      <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (load_i) begin
                if (!valid_q || ready_i) begin
                    data_q      <= word_i;
                    par_err_q   <= par_err_i;
                    frame_err_q <= frame_err_i;
                    valid_q     <= 1'b1;
                    overrun_q   <= 1'b0;
                end else begin
                    overrun_q   <= 1'b1;
                end
            end else begin
                overrun_q <= 1'b0;
                if (valid_q && ready_i) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= valid_q;
                end
            end
        end
    end

    assign data_o      = data_q;
    assign par_err_o   = par_err_q;
    assign frame_err_o = frame_err_q;
    assign valid_o     = valid_q;
    assign overrun_o   = overrun_q;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial start/data/parity/stop frame receiver with parity and framing checks.
// Words are delivered through a one-entry valid/ready buffer (par_rx_outbuf).
// Optional feature: define PARITY_ERR_CNT_EN to add the saturating parity-error
// counter with its CntClr/ErrCount ports.
module parity_frame_rx
    import parity_rx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter bit ODD_PAR = 1'b0
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic              BitEn,
    input  logic              SerIn,
    output logic [DATA_W-1:0] OutData,
    output logic              ParErr,
    output logic              FrameErr,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              Overrun
`ifdef PARITY_ERR_CNT_EN
    ,
    input  logic                 CntClr,
    output logic [ERR_CNT_W-1:0] ErrCount
`endif
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_t         state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              par_q;

    logic              load_s;
    logic              par_err_s;
    logic              frame_err_s;

    // Next data word: the sampled bit lands at the current bit index, LSB first.
    always_comb begin
        data_d = data_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (idx_q == IDX_W'(i)) begin
                data_d[i] = SerIn;
            end else begin
                data_d[i] = data_q[i];
            end
        end
    end

    // Frame FSM: advances only on bit strobes; reset discards any partial frame.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
        end else if (BitEn) begin
            case (state_q)
                IDLE: begin
                    if (!SerIn) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    data_q <= data_d;
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        state_q <= PARITY;
                        idx_q   <= '0;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                PARITY: begin
                    par_q   <= SerIn;
                    state_q <= STOP;
                end
                STOP: begin
                    // A low stop bit parks the receiver until the line returns high.
                    if (SerIn) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (SerIn) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT_HIGH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
            endcase
        end else begin
            state_q <= state_q;
        end
    end

    // Completion decode: the stop-bit sample loads the word and flags into the buffer.
    always_comb begin
        load_s      = 1'b0;
        frame_err_s = ~SerIn;
        par_err_s   = calc_par_err(16'(data_q), par_q, ODD_PAR);
        if (BitEn && (state_q == STOP)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    par_rx_outbuf #(
        .DATA_W (DATA_W)
    ) u_outbuf (
        .clk_i       (Clk),
        .rst_n_i     (RstN),
        .load_i      (load_s),
        .word_i      (data_q),
        .par_err_i   (par_err_s),
        .frame_err_i (frame_err_s),
        .ready_i     (OutReady),
        .data_o      (OutData),
        .par_err_o   (ParErr),
        .frame_err_o (FrameErr),
        .valid_o     (OutValid),
        .overrun_o   (Overrun)
    );

`ifdef PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 cnt_inc_s;

    // Only words actually accepted into the buffer are counted; drops are not.
    assign cnt_inc_s = load_s && par_err_s && (!OutValid || OutReady);

    // Saturating parity-error counter; clear wins over a same-edge increment.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            err_cnt_q <= '0;
        end else if (CntClr) begin
            err_cnt_q <= '0;
        end else if (cnt_inc_s && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end else begin
            err_cnt_q <= err_cnt_q;
        end
    end

    assign ErrCount = err_cnt_q;
`else
    // No parity-error counter in this build.
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: an even-parity and an odd-parity instance share
// the same serial stimulus; a scoreboard queue holds the expected words.
module tb_parity_frame_rx;

    logic       Clk = 1'b0;
    logic       RstN;
    logic       BitEn;
    logic       SerIn;
    logic       OutReady;
    logic [7:0] d0, d1;
    logic       pe0, pe1, fe0, fe1, v0, v1, ov0, ov1;
`ifdef PARITY_ERR_CNT_EN
    logic        CntClr;
    logic [15:0] ec0, ec1;
    int          cnt0, cnt1;
`endif

    typedef struct {
        logic [7:0] d;
        logic       pe;   // expected ParErr for the even-parity instance
        logic       fe;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   pops = 0;
    int   ovr_cnt0 = 0;
    int   ovr_cnt1 = 0;
    int   gap_max = 0;

    always #5 Clk = ~Clk;

    parity_frame_rx #(.DATA_W(8), .ODD_PAR(1'b0)) dut0 (
        .Clk(Clk), .RstN(RstN), .BitEn(BitEn), .SerIn(SerIn),
        .OutData(d0), .ParErr(pe0), .FrameErr(fe0), .OutValid(v0),
        .OutReady(OutReady), .Overrun(ov0)
`ifdef PARITY_ERR_CNT_EN
        , .CntClr(CntClr), .ErrCount(ec0)
`endif
    );

    parity_frame_rx #(.DATA_W(8), .ODD_PAR(1'b1)) dut1 (
        .Clk(Clk), .RstN(RstN), .BitEn(BitEn), .SerIn(SerIn),
        .OutData(d1), .ParErr(pe1), .FrameErr(fe1), .OutValid(v1),
        .OutReady(OutReady), .Overrun(ov1)
`ifdef PARITY_ERR_CNT_EN
        , .CntClr(CntClr), .ErrCount(ec1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare every word accepted by the consumer.
    always @(negedge Clk) begin
        if (RstN === 1'b1) begin
            if (ov0) ovr_cnt0++;
            if (ov1) ovr_cnt1++;
            if (v0 && OutReady) begin
                if (q.size() == 0) begin
                    check("unexpected_word", {24'd0, d0}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    pops++;
                    check("sb_data0", {24'd0, d0}, {24'd0, e.d});
                    check("sb_pe0", {31'd0, pe0}, {31'd0, e.pe});
                    check("sb_fe0", {31'd0, fe0}, {31'd0, e.fe});
                    check("sb_valid1", {31'd0, v1}, 32'd1);
                    check("sb_data1", {24'd0, d1}, {24'd0, e.d});
                    check("sb_pe1", {31'd0, pe1}, {31'd0, ~e.pe});
                    check("sb_fe1", {31'd0, fe1}, {31'd0, e.fe});
                end
            end
        end
    end

    task automatic expect_word(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe;
        q.push_back(e);
`ifdef PARITY_ERR_CNT_EN
        if (pe) cnt0++;
        else    cnt1++;
`endif
    endtask

    task automatic strobe(input logic b);
        int g;
        SerIn = b;
        BitEn = 1'b1;
        @(posedge Clk); #1;
        BitEn = 1'b0;
        g = $urandom_range(0, gap_max);
        repeat (g) begin
            SerIn = 1'($urandom_range(0, 1));
            @(posedge Clk); #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic rdy_at_stop);
        strobe(1'b0);
        for (int i = 0; i < 8; i++) strobe(d[i]);
        strobe(p);
        if (rdy_at_stop) OutReady = 1'b1;
        strobe(s);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) begin
            @(posedge Clk); #1;
        end
        check("drain_empty", q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data0"}, {24'd0, d0}, 32'd0);
        check({tag, "_flags0"}, {28'd0, pe0, fe0, v0, ov0}, 32'd0);
        check({tag, "_data1"}, {24'd0, d1}, 32'd0);
        check({tag, "_flags1"}, {28'd0, pe1, fe1, v1, ov1}, 32'd0);
`ifdef PARITY_ERR_CNT_EN
        check({tag, "_errcnt"}, {ec1, ec0}, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        int   ov_before;
        int   pops_before;

        vecs[0]  = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{8'h7F, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{8'hFE, 1'b1, 1'b0, 1'b0, 1'b1};

        RstN = 1'b0; BitEn = 1'b0; SerIn = 1'b1; OutReady = 1'b0;
`ifdef PARITY_ERR_CNT_EN
        CntClr = 1'b0; cnt0 = 0; cnt1 = 0;
`endif
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        RstN = 1'b1;
        repeat (2) @(posedge Clk);
        #1;

        // Latency: word becomes visible on the stop-bit (10th) strobe edge.
        strobe(1'b0);
        for (int i = 0; i < 8; i++) strobe(vecs[0].data[i]);
        strobe(1'b0);
        check("latency_before_stop", {31'd0, v0}, 32'd0);
        expect_word(8'hA5, 1'b0, 1'b0);
        strobe(1'b1);
        check("first_valid0", {31'd0, v0}, 32'd1);
        check("first_data0", {24'd0, d0}, 32'hA5);
        check("first_flags0", {30'd0, pe0, fe0}, 32'd0);
        check("first_pe1", {31'd0, pe1}, 32'd1);
        OutReady = 1'b1;
        @(posedge Clk); #1;
        check("pop_clears_valid", {31'd0, v0}, 32'd0);
        check("pop_keeps_data", {24'd0, d0}, 32'hA5);

        // Table-driven frames with random strobe gaps and noise between strobes.
        gap_max = 2;
        foreach (vecs[k]) begin
            expect_word(vecs[k].data, vecs[k].exp_pe, vecs[k].exp_fe);
            send_frame(vecs[k].data, vecs[k].par, vecs[k].stop, 1'b0);
            strobe(1'b1);
        end
        gap_max = 0;
        drain();
`ifdef PARITY_ERR_CNT_EN
        check("errcnt_table0", {16'd0, ec0}, 32'(cnt0));
        check("errcnt_table1", {16'd0, ec1}, 32'(cnt1));
        CntClr = 1'b1;
        @(posedge Clk); #1;
        CntClr = 1'b0;
        cnt0 = 0; cnt1 = 0;
        check("errcnt_clear", {ec1, ec0}, 32'd0);
        // Clear on the same edge as a parity-error load wins.
        q.push_back('{8'hA5, 1'b1, 1'b0});
        strobe(1'b0);
        for (int i = 0; i < 8; i++) strobe(vecs[0].data[i]);
        strobe(1'b1);
        CntClr = 1'b1;
        strobe(1'b1);
        CntClr = 1'b0;
        check("errcnt_clr_priority", {16'd0, ec0}, 32'd0);
        expect_word(8'hA5, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        check("errcnt_after_one", {16'd0, ec0}, 32'd1);
        drain();
`endif

        // Low stop bit, then line held low: no new frames until it returns high.
        expect_word(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (20) strobe(1'b0);
        drain();
        pops_before = pops;
        repeat (4) @(posedge Clk);
        #1;
        check("held_low_no_frame", pops - pops_before, 32'd0);
        check("held_low_valid", {31'd0, v0}, 32'd0);
        strobe(1'b1);
        expect_word(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        drain();

        // Overrun: second word dropped while the first is held.
        OutReady = 1'b0;
        ov_before = ovr_cnt0;
        expect_word(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge Clk);
        #1;
        check("overrun_keeps_data", {24'd0, d0}, 32'h11);
        check("overrun_pulse_once", ovr_cnt0 - ov_before, 32'd1);
        check("overrun_dut1", ovr_cnt1 - ov_before, 32'd1);
`ifdef PARITY_ERR_CNT_EN
        check("overrun_not_counted", {16'd0, ec1}, 32'(cnt1));
`endif
        OutReady = 1'b1;
        drain();

        // Replacement: pop and completion on the same edge.
        OutReady = 1'b0;
        ov_before = ovr_cnt0;
        expect_word(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        expect_word(8'h22, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        check("replace_valid", {31'd0, v0}, 32'd1);
        check("replace_data", {24'd0, d0}, 32'h22);
        drain();
        check("replace_no_overrun", ovr_cnt0 - ov_before, 32'd0);

        // Reset in the middle of a frame discards the partial word.
        strobe(1'b0);
        repeat (4) strobe(1'b1);
        RstN = 1'b0;
        #2;
        check_reset_outputs("midreset");
        @(posedge Clk); #1;
        RstN = 1'b1;
`ifdef PARITY_ERR_CNT_EN
        cnt0 = 0; cnt1 = 0;
`endif
        @(posedge Clk); #1;
        expect_word(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        strobe(1'b1);
        drain();
        pops_before = pops;
        repeat (15) strobe(1'b1);
        check("post_reset_single_word", pops - pops_before, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
